uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver for 8 data bits and 1 stop bit, with a one-byte holding register and a valid/ready handshake.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RxD,
  input  logic       Ready,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       Frame_Err,
  output logic       Parity_Err,
  output logic       Overrun,
  output logic       Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, WAIT_HIGH = 3'd5
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          deliver_s;
  logic          rx_s;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  assign rx_s = sync_q[1];

  // Next-state, datapath and delivery logic.
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], RxD};
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    deliver_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    if (valid_q && Ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = 3'd0;
          // A start bit that is already gone at mid-bit was a glitch.
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          shreg_d[idx_q] = rx_s;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          par_d   = rx_s;
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          perr_d = ~even_parity_ok(shreg_q, par_q);
`endif
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            deliver_s = even_parity_ok(shreg_q, par_q);
`else
            deliver_s = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (deliver_s) begin
      if (!valid_q || Ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      ovr_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign Data      = data_q;
  assign Valid     = valid_q;
  assign Frame_Err = ferr_q;
  assign Overrun   = ovr_q;
  assign Busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign Parity_Err = perr_q;
`else
  assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16: a byte-level scoreboard plus pulse and latency checks.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + PBITS * CPB;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       RxD = 1'b1;
  logic       Ready = 1'b1;
  logic [7:0] Data;
  logic       Valid, Frame_Err, Parity_Err, Overrun, Busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .Clk(Clk), .Reset(Reset), .RxD(RxD), .Ready(Ready), .Data(Data), .Valid(Valid),
    .Frame_Err(Frame_Err), .Parity_Err(Parity_Err), .Overrun(Overrun), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_arr [0:15];
  int exp_wr = 0, exp_rd = 0;
  int exp_ferr = 0, seen_ferr = 0;
  int exp_perr = 0, seen_perr = 0;
  int exp_ovr = 0, seen_ovr = 0;
  int t_start = 0;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Per-cycle comparison against the byte scoreboard and expected pulse counts.
  initial begin : compare
    logic p_valid, p_ready, p_ferr, p_perr, p_ovr;
    logic [7:0] p_data;
    int d;
    p_valid = 1'b0; p_ready = 1'b0; p_ferr = 1'b0; p_perr = 1'b0; p_ovr = 1'b0; p_data = 8'h00;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        if (Valid && !p_valid) begin
          d = cyc - t_start;
          checks++;
          if (d < LAT - 1 || d > LAT + 1) begin
            errors++;
            $display("FAIL valid_latency: got %0d cycles, required %0d +/-1", d, LAT);
          end
        end
        if (Valid && Ready) begin
          if (exp_rd < exp_wr) begin
            chk("data_accepted", int'(Data), int'(exp_arr[exp_rd % 16]));
            exp_rd++;
          end else begin
            chk("unexpected_valid", int'(Valid), 0);
          end
        end
        if (p_valid && !p_ready && Valid) chk("data_hold", int'(Data), int'(p_data));
        if (Frame_Err) begin
          seen_ferr++;
          chk("frame_err_expected", int'(seen_ferr <= exp_ferr), 1);
          chk("frame_err_one_cycle", int'(p_ferr), 0);
        end
        if (Parity_Err) begin
          seen_perr++;
          chk("parity_err_expected", int'(seen_perr <= exp_perr), 1);
          chk("parity_err_one_cycle", int'(p_perr), 0);
        end
        if (Overrun) begin
          seen_ovr++;
          chk("overrun_expected", int'(seen_ovr <= exp_ovr), 1);
          chk("overrun_one_cycle", int'(p_ovr), 0);
        end
      end
      p_valid = Valid; p_ready = Ready; p_ferr = Frame_Err; p_perr = Parity_Err; p_ovr = Overrun; p_data = Data;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Drives one frame and records what the receiver must make of it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, input int extra_low);
    logic good;
    @(posedge Clk);
    #1;
    RxD = 1'b0;
    t_start = cyc;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      if (i == 4) chk("busy_mid_frame", int'(Busy), 1);
      idle(CPB);
    end
    good = stop;
    if (PBITS == 1) begin
      RxD = par;
      idle(CPB);
      if (^{b, par}) begin
        exp_perr++;
        good = 1'b0;
      end
    end
    if (!stop) exp_ferr++;
    if (good) begin
      if ((exp_wr - exp_rd) > 0 && !Ready) begin
        exp_ovr++;
      end else begin
        exp_arr[exp_wr % 16] = b;
        exp_wr++;
      end
    end
    RxD = stop;
    idle(CPB);
    if (!stop) idle(extra_low);
    RxD = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, int'(Data), 0);
    chk({tag, "_valid"}, int'(Valid), 0);
    chk({tag, "_frame_err"}, int'(Frame_Err), 0);
    chk({tag, "_parity_err"}, int'(Parity_Err), 0);
    chk({tag, "_overrun"}, int'(Overrun), 0);
    chk({tag, "_busy"}, int'(Busy), 0);
  endtask

  initial begin : stim
    int t;
    logic [7:0] f0;
    idle(3);
    check_all_zero("reset");
    Reset = 1'b1;
    idle(5);

    // Two back-to-back good bytes with Ready held high.
    send_frame(8'h55, 1'b1, 1'b0, 0);
    idle(20);
    chk("t1_first_byte_held", int'(Data), 8'h55);
    send_frame(8'hA3, 1'b1, 1'b0, 0);
    idle(20);
    chk("t1_second_byte_held", int'(Data), 8'hA3);
    chk("t1_valid_consumed", int'(Valid), 0);
    chk("t1_idle_after", int'(Busy), 0);

    // Five-cycle low glitch must be rejected.
    @(posedge Clk);
    #1;
    RxD = 1'b0;
    t = cyc;
    idle(4);
    chk("glitch_busy_in_start", int'(Busy), 1);
    idle(1);
    RxD = 1'b1;
    idle(t + 12 - cyc);
    chk("glitch_idle_by_12", int'(Busy), 0);
    idle(20);

    // Low stop bit followed by a long break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, 40);
    idle(30);
    chk("ferr_data_kept", int'(Data), 8'hA3);
    chk("ferr_pulse_seen", seen_ferr, 1);
    send_frame(8'h7E, 1'b1, 1'b0, 0);
    idle(20);
    chk("after_ferr_byte", int'(Data), 8'h7E);

    // Overrun while the consumer stalls.
    Ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 0);
    idle(20);
    chk("ovr_valid_held", int'(Valid), 1);
    chk("ovr_first_data", int'(Data), 8'h11);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    idle(20);
    chk("ovr_data_kept", int'(Data), 8'h11);
    chk("ovr_pulse_seen", seen_ovr, 1);
    Ready = 1'b1;
    idle(1);
    chk("ovr_valid_cleared", int'(Valid), 0);
    idle(10);

    // Asynchronous reset during bit 4 of 0xF0, then 0x0F.
    f0 = 8'hF0;
    @(posedge Clk);
    #1;
    RxD = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      RxD = f0[i];
      idle(CPB);
    end
    RxD = f0[4];
    idle(8);
    #2;
    Reset = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(3);
    Reset = 1'b1;
    idle(200);
    chk("after_reset_no_valid", int'(Valid), 0);
    send_frame(8'h0F, 1'b1, 1'b0, 0);
    idle(20);
    chk("after_reset_byte", int'(Data), 8'h0F);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(20);
    chk("parity_good_byte", int'(Data), 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle(20);
    chk("parity_bad_pulse", seen_perr, 1);
    chk("parity_bad_no_valid", int'(Valid), 0);
`endif

    chk("all_bytes_consumed", exp_rd, exp_wr);
    chk("frame_err_total", seen_ferr, exp_ferr);
    chk("parity_err_total", seen_perr, exp_perr);
    chk("overrun_total", seen_ovr, exp_ovr);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
